execute_stage: RTL

Execute/writeback stage directly downstream of `Controlpath`. Each cycle it consumes one decoded operation (`alu_op`, register addresses, immediate, accumulate/write/halt flags), reads operands from a 16-entry register file, computes the ALU result, optionally folds it into an accumulator, and writes back one cycle later. It is a two-stage pipeline (EX, WB) with EX←WB bypass, so back-to-back dependent operations need no stalls.

---
 rtl/execute_pkg.sv | 27 ++
 rtl/execute_stage_register_file.sv | 44 ++++
 rtl/execute_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// execute_pkg
// Shared opcode definitions for the execute/writeback stage.
//   alu_op_e    : opcode enumeration (OP_NOP .. OP_MOVB); every other value is illegal
//   is_legal_op : true for the defined opcodes, including OP_NOP
package execute_pkg;

  localparam int OP_WIDTH = 6;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_SLL  = 6'h06,
    OP_SRL  = 6'h07,
    OP_MUL  = 6'h08,
    OP_MOVB = 6'h09
  } alu_op_e;

  // The defined opcodes form a contiguous range starting at zero.
  function automatic logic is_legal_op(input logic [OP_WIDTH-1:0] op);
    return (op <= OP_MOVB);
  endfunction

endpackage

// File: rtl/execute_stage_register_file.sv
// register_file
// Architectural register file used by the execute stage.
//   clock, reset             : rising-edge clock, synchronous active-high clear of all entries
//   read1_addr / read1_data  : asynchronous read port (operand A)
//   read2_addr / read2_data  : asynchronous read port (operand B)
//   dbg_addr / dbg_data      : asynchronous debug read port
//   write_en, write_addr,
//   write_data               : synchronous write port
module register_file #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] read1_addr,
  output logic [DATA_BITS-1:0] read1_data,
  input  logic [ADDR_BITS-1:0] read2_addr,
  output logic [DATA_BITS-1:0] read2_data,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0] dbg_data,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read1_data = regs[read1_addr];
  assign read2_data = regs[read2_addr];
  assign dbg_data   = regs[dbg_addr];

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Two-stage (EX, WB) execute/writeback pipeline fed by the control path.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   alu_op            : opcode sampled every cycle
//   use_immediate     : operand B is the zero-extended immediate
//   use_accumulate    : result is accumulator + ALU value; accumulator updated
//   read1/read2_addr  : operand A/B source registers
//   immediate         : immediate operand
//   write_addr(_en)   : destination register and write enable
//   halt              : halt request; halted is sticky until reset
//   dbg_addr/dbg_data : architectural register read, no bypass
//   result(_valid)    : registered result of the previous cycle's operation
//   accumulator       : accumulator register
//   illegal           : one-cycle pulse for an undefined opcode
module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_BITS         = 32,
  parameter int REGFILE_ADDR_BITS = 4,
  parameter int IMMEDIATE_BITS    = 8,
  parameter int ALU_OP_BITS       = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ALU_OP_BITS-1:0]       alu_op,
  input  logic                         use_immediate,
  input  logic                         use_accumulate,
  input  logic [REGFILE_ADDR_BITS-1:0] read1_addr,
  input  logic [REGFILE_ADDR_BITS-1:0] read2_addr,
  input  logic [IMMEDIATE_BITS-1:0]    immediate,
  input  logic [REGFILE_ADDR_BITS-1:0] write_addr,
  input  logic                         write_addr_en,
  input  logic                         halt,
  input  logic [REGFILE_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0]         result,
  output logic                         result_valid,
  output logic [DATA_BITS-1:0]         accumulator,
  output logic                         illegal,
  output logic                         halted,
  output logic [DATA_BITS-1:0]         dbg_data
);

  localparam int SHAMT_BITS = $clog2(DATA_BITS);

  logic [DATA_BITS-1:0]         rf_read1;
  logic [DATA_BITS-1:0]         rf_read2;
  logic [DATA_BITS-1:0]         op_a;
  logic [DATA_BITS-1:0]         op_b;
  logic [DATA_BITS-1:0]         alu_value;
  logic [DATA_BITS-1:0]         final_value;
  logic [SHAMT_BITS-1:0]        shamt;
  logic                         accept;
  logic                         op_legal;
  logic                         op_active;

  logic                         wb_valid;
  logic [REGFILE_ADDR_BITS-1:0] wb_addr;
  logic [DATA_BITS-1:0]         wb_data;

  register_file #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (REGFILE_ADDR_BITS)
  ) u_register_file (
    .clock      (clock),
    .reset      (reset),
    .read1_addr (read1_addr),
    .read1_data (rf_read1),
    .read2_addr (read2_addr),
    .read2_data (rf_read2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .write_en   (wb_valid),
    .write_addr (wb_addr),
    .write_data (wb_data)
  );

  // A halt request discards its own cycle's operation, and once halted
  // every decode input is ignored.
  assign accept    = !halted && !halt;
  assign op_legal  = is_legal_op(alu_op);
  assign op_active = accept && op_legal && (alu_op != OP_NOP);

  // The register file is written one cycle after EX, so the pending WB
  // value is forwarded on each read port independently.
  assign op_a  = (wb_valid && (wb_addr == read1_addr)) ? wb_data : rf_read1;
  assign op_b  = use_immediate ? DATA_BITS'(immediate)
               : ((wb_valid && (wb_addr == read2_addr)) ? wb_data : rf_read2);
  assign shamt = op_b[SHAMT_BITS-1:0];

  always_comb begin
    alu_value = '0;
    case (alu_op)
      OP_ADD:  alu_value = op_a + op_b;
      OP_SUB:  alu_value = op_a - op_b;
      OP_AND:  alu_value = op_a & op_b;
      OP_OR:   alu_value = op_a | op_b;
      OP_XOR:  alu_value = op_a ^ op_b;
      OP_SLL:  alu_value = op_a << shamt;
      OP_SRL:  alu_value = op_a >> shamt;
      OP_MUL:  alu_value = op_a * op_b;
      OP_MOVB: alu_value = op_b;
      default: alu_value = '0;
    endcase
  end

  assign final_value = use_accumulate ? (accumulator + alu_value) : alu_value;

  // EX/WB pipeline register plus the architecturally visible outputs.
  // result and the WB payload only move on an active operation, so NOPs
  // and illegal opcodes leave result holding its previous value.
  always_ff @(posedge clock) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      accumulator  <= '0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
    end else begin
      result_valid <= op_active;
      illegal      <= accept && !op_legal;
      wb_valid     <= op_active && write_addr_en;
      if (op_active) begin
        result  <= final_value;
        wb_addr <= write_addr;
        wb_data <= final_value;
        if (use_accumulate) begin
          accumulator <= final_value;
        end
      end
      if (halt && !halted) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
